uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver that is the downstream counterpart of uart_tx. It consumes the serial line produced by the transmitter and samples it with the shared uart_baudgen oversampling tick. It reassembles frames of the form start, data_wd data bits sent LSB first, optional parity, and stop. It then presents the parallel word with a one-cycle done pulse and parity/framing error flags.

Parameters:
BAUD, 9600, line baud rate (bits/s); informational, tick comes from uart_baudgen
clk_freq, 50_000_000, system clock frequency in Hz
oversampling_rate, 16, ticks per bit; must be even and >= 4
data_wd, 8, data bits per frame
parity, 1, 2-bit: 1 = odd, 2 = even, any other value = no parity bit

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
tick  input  1  one-clk-wide pulse at BAUD*oversampling_rate, from uart_baudgen
rx  input  1  serial line, idle high, asynchronous to clk
dout  output  data_wd  last received data word
rx_done  output  1  one-clk pulse when a frame completes
rx_busy  output  1  high while a frame is being received (any state except IDLE)
parity_err  output  1  parity mismatch on the last frame
frame_err  output  1  stop bit sampled low on the last frame

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: dout=0, rx_done=0, rx_busy=0, parity_err=0, frame_err=0, state=IDLE, tick_count=0, bit_index=0, shift register=0, synchronizer flops=1.
- Input synchronization: rx always passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
- State encoding: one-hot, using IDLE=000001, START=000010, DATA=000100, PARITY=001000, STOP=010000, DONE=100000.
- Counters: tick_count counts ticks only and is reset on every state entry. bit_index spans 0..data_wd-1.
- IDLE: rx_busy=0. When rx_s==0 on any clk, go to START with tick_count=0. This does not wait for a tick.
- START: on the tick where tick_count reaches oversampling_rate/2-1 (the start-bit centre), sample rx_s.
  - rx_s==1: false start. Return to IDLE with no flags and no rx_done.
  - rx_s==0: go to DATA with tick_count=0 and bit_index=0.
- DATA: on every oversampling_rate-th tick (the bit centre), shift rx_s into the MSB of a right-shifting register, giving LSB-first order, and increment bit_index.
  - After bit data_wd-1, go to PARITY if parity is 1 or 2, otherwise go to STOP.
- PARITY: sample at the bit centre.
  - Odd parity: error if (^data ^ bit) == 0.
  - Even parity: error if (^data ^ bit) == 1.
  - The result is held internally, then the FSM goes to STOP.
- STOP: sample at the bit centre. frame_err_next = ~rx_s. Go to DONE immediately so the receiver is ready half a bit before the next start edge.
- DONE: one clk only.
  - dout <= shift register, rx_done=1 for exactly one clk.
  - parity_err and frame_err are loaded; both are 0 when parity is disabled, for parity_err.
  - Go to IDLE.
- Flags and dout hold until the next DONE. A frame with errors still updates dout.
- Latency: the rx_done rising edge follows the stop-bit centre by 1 clk. With 50 MHz, 9600 baud, 16x, 8O1 this is about 10.5 bit times from the start-edge.
- rx_done and rx_busy: rx_busy=1 from START entry through DONE. rx_busy is 0 on the clk after rx_done.
- Back-to-back frames: a start edge arriving during DONE is seen in IDLE on the next clk. No frame is lost at full line rate.
- Reset mid-frame: abort immediately to reset values. No rx_done for the partial frame. A line still mid-frame after release is resynchronised on the next high-to-low transition.
- Break (rx held low): the frame completes with frame_err=1 and dout=0. The FSM then re-enters START only after rx_s returns high and falls again, with IDLE waiting for a high first.

Optional Feature:
UART_RX_MAJORITY_EN.
- Defined: each data, parity and stop sample is the 2-of-3 majority of rx_s at the centre tick and the ticks immediately before and after it. The start-bit check uses the same vote. Adds 2 sample flops.
- Undefined: single sample at the centre tick.
- Timing and outputs are otherwise identical.

Test Plan:
- Reset: hold rst 10 clks, rx=1 -> all outputs 0, state=IDLE, tick_count=0, bit_index=0.
- Odd-parity frame: uart_tx (parity=1) sends 0xA5 into rx -> one rx_done pulse, dout=0xA5, parity_err=0, frame_err=0, rx_busy low afterwards.
- Back-to-back frames: 10 consecutive uart_tx frames 0x00, 0xFF, 0x55, 0xAA, 0x01..0x06 -> 10 rx_done pulses, each dout matching in order, no errors.
- Errors: bench-driven frame 0x3C with a wrong parity bit -> parity_err=1. Next frame 0x3C with stop=0 -> frame_err=1, parity_err=0, dout=0x3C.
- False start and glitch: rx low for 3 ticks then high -> no rx_done, returns to IDLE, rx_busy pulses only briefly. With UART_RX_MAJORITY_EN, a 1-tick glitch at a data-bit centre of 0x0F -> dout=0x0F.
- Reset mid-frame: assert rst during data bit 4 of 0x81 -> no rx_done. The following full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, downstream counterpart of uart_tx.
// Frame: start, data_wd data bits (LSB first), optional parity, stop.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   tick       in   1-clk pulse at BAUD*oversampling_rate (from uart_baudgen)
//   rx         in   serial line, idle high, asynchronous to clk
//   dout       out  last received data word
//   rx_done    out  1-clk pulse when a frame completes
//   rx_busy    out  high whenever the FSM is outside IDLE
//   parity_err out  parity mismatch on the last frame
//   frame_err  out  stop bit sampled low on the last frame
//
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx #(
   parameter int unsigned BAUD              = 9600,
   parameter int unsigned clk_freq          = 50_000_000,
   parameter int unsigned oversampling_rate = 16,
   parameter int unsigned data_wd           = 8,
   parameter logic [1:0]  parity            = 2'd1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               rx,
   output logic [data_wd-1:0] dout,
   output logic               rx_done,
   output logic               rx_busy,
   output logic               parity_err,
   output logic               frame_err
);

   if ((oversampling_rate % 2) != 0 || oversampling_rate < 4 || data_wd < 2 ||
       clk_freq < BAUD * oversampling_rate) begin : g_cfg_check
      $error("uart_rx: invalid configuration");
   end

   localparam int unsigned TW = $clog2(oversampling_rate);
   localparam int unsigned BW = $clog2(data_wd);
   localparam logic [TW-1:0] HALF_M1  = TW'(oversampling_rate / 2 - 1);
   localparam logic [TW-1:0] FULL_M1  = TW'(oversampling_rate - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(data_wd - 1);
   localparam logic          HAS_PAR  = (parity == 2'd1) || (parity == 2'd2);

   typedef enum logic [5:0] {
      S_IDLE   = 6'b000001,
      S_START  = 6'b000010,
      S_DATA   = 6'b000100,
      S_PARITY = 6'b001000,
      S_STOP   = 6'b010000,
      S_DONE   = 6'b100000
   } state_t;

   state_t             state_q, state_d;
   logic               rx_m_q, rx_s_q;
   logic [1:0]         vld_q;
   logic               arm_q, arm_d;
   logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]      bit_idx_q, bit_idx_d;
   logic [data_wd-1:0] shreg_q, shreg_d;
   logic               par_pend_q, par_pend_d;
   logic [data_wd-1:0] dout_q, dout_d;
   logic               perr_q, perr_d;
   logic               ferr_q, ferr_d;
   logic               bit_smp;
   logic               par_calc;
   logic               at_half, at_full;

`ifdef UART_RX_MAJORITY_EN
   // The vote window is the decision tick plus the two ticks before it, so the
   // decision lands on the same tick as the single-sample build.
   logic [1:0] samp_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_q <= '1;
      end else if (tick) begin
         samp_q <= {samp_q[0], rx_s_q};
      end
   end

   assign bit_smp = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s_q) | (samp_q[0] & rx_s_q);
`else
   assign bit_smp = rx_s_q;
`endif

   assign at_half  = tick && (tick_cnt_q == HALF_M1);
   assign at_full  = tick && (tick_cnt_q == FULL_M1);
   assign par_calc = (^shreg_q) ^ bit_smp;

   always_comb begin
      state_d    = state_q;
      arm_d      = arm_q;
      tick_cnt_d = tick_cnt_q;
      bit_idx_d  = bit_idx_q;
      shreg_d    = shreg_q;
      par_pend_d = par_pend_q;
      dout_d     = dout_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;

      // arm_q means "line seen high since the last stop sample". vld_q masks
      // the synchronizer reset value so a line that is low when reset is
      // released is not mistaken for a start edge.
      if (vld_q[1] && rx_s_q) arm_d = 1'b1;
      if (tick) tick_cnt_d = tick_cnt_q + TW'(1);

      unique case (state_q)
         S_IDLE: begin
            tick_cnt_d = '0;
            if (!rx_s_q && arm_q) begin
               state_d = S_START;
               arm_d   = 1'b0;
            end
         end
         S_START: begin
            if (at_half) begin
               tick_cnt_d = '0;
               if (bit_smp) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_DATA;
                  bit_idx_d = '0;
               end
            end
         end
         S_DATA: begin
            if (at_full) begin
               tick_cnt_d = '0;
               shreg_d    = {bit_smp, shreg_q[data_wd-1:1]};
               bit_idx_d  = bit_idx_q + BW'(1);
               if (bit_idx_q == LAST_BIT) begin
                  bit_idx_d = '0;
                  state_d   = HAS_PAR ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (at_full) begin
               tick_cnt_d = '0;
               par_pend_d = (parity == 2'd1) ? ~par_calc : par_calc;
               state_d    = S_STOP;
            end
         end
         S_STOP: begin
            // Results are loaded on entry to DONE so they are already valid
            // during the rx_done pulse.
            if (at_full) begin
               tick_cnt_d = '0;
               state_d    = S_DONE;
               dout_d     = shreg_q;
               perr_d     = HAS_PAR & par_pend_q;
               ferr_d     = ~bit_smp;
               arm_d      = bit_smp;
            end
         end
         S_DONE: begin
            tick_cnt_d = '0;
            state_d    = S_IDLE;
         end
         default: begin
            tick_cnt_d = '0;
            state_d    = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rx_m_q     <= 1'b1;
         rx_s_q     <= 1'b1;
         vld_q      <= '0;
         arm_q      <= 1'b0;
         tick_cnt_q <= '0;
         bit_idx_q  <= '0;
         shreg_q    <= '0;
         par_pend_q <= 1'b0;
         dout_q     <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_m_q     <= rx;
         rx_s_q     <= rx_m_q;
         vld_q      <= {vld_q[0], 1'b1};
         arm_q      <= arm_d;
         tick_cnt_q <= tick_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shreg_q    <= shreg_d;
         par_pend_q <= par_pend_d;
         dout_q     <= dout_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
      end
   end

   assign dout       = dout_q;
   assign rx_done    = (state_q == S_DONE);
   assign rx_busy    = (state_q != S_IDLE);
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;

endmodule
